sweep_uart_dump: RTL

Downstream readout stage for the ADC sweep. When a sweep completes, it walks the 12-bit sample memory from index 0 to NUM_POINTS-1 and streams each sample over a UART TX line as three uppercase ASCII hex digits followed by CR LF, at 8N1. It attaches to the sweep memory through a synchronous read port and is triggered by the sweep `done` pulse.

---
 rtl/sweep_uart_dump_pkg.sv | 31 +++
 rtl/sweep_uart_dump_if.sv | 30 +++
 rtl/sweep_uart_dump_uart.sv | 63 ++++++
 rtl/sweep_uart_dump.sv | 116 +++++++++++
 4 files changed

// File: rtl/sweep_uart_dump_pkg.sv
// sweep_uart_dump shared types: controller states, line-end bytes,
// nibble-to-ASCII helper. No ports.
package sweep_uart_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_NEXT  = 3'd5,
    S_DRAIN = 3'd6
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // index of the last character of a sample line
  localparam logic [2:0] LAST_CHAR = 3'd4;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(
    input logic [3:0] n
  );
    logic [7:0] w;
    w = {4'h0, n};
    if (n < 4'd10) hex_ascii = 8'h30 + w;
    else hex_ascii = 8'h37 + w;
  endfunction

endpackage

// File: rtl/sweep_uart_dump_if.sv
// sweep_uart_dump bus: start/busy/done control, sample memory read
// port and the serial line. slave = dump block, master = host side.
interface sweep_uart_dump_if;

  logic        start;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;
  logic        uart_tx;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output rd_data,
    input  rd_addr,
    input  uart_tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  rd_data,
    output rd_addr,
    output uart_tx,
    output busy,
    output done
  );

endinterface

// File: rtl/sweep_uart_dump_uart.sv
// uart_tx_byte: 8N1 byte serializer, CLK_DIV clocks per bit.
// Ports: clk, rst, valid/data/ready handshake, fin, tx.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       fin,
  output logic       tx
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);

  logic          active;
  logic [8:0]    shift;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  assign ready = !active;

  // high during the final clock of the stop bit
  assign fin = active
    && (bit_cnt == 4'd9)
    && (div_cnt == DIV_LAST);

  // tx holds the bit on the line; shift holds
  // the remaining data bits followed by stop
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      shift   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
      tx      <= 1'b1;
    end else if (!active) begin
      if (valid) begin
        active  <= 1'b1;
        shift   <= {1'b1, data};
        bit_cnt <= '0;
        div_cnt <= '0;
        tx      <= 1'b0;
      end
    end else if (div_cnt != DIV_LAST) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        tx      <= shift[0];
        shift   <= {1'b1, shift[8:1]};
      end
    end
  end

endmodule

// File: rtl/sweep_uart_dump.sv
// sweep_uart_dump: streams NUM_POINTS 12-bit samples as hex+CRLF.
// Ports: clk, rst, bus (start, rd_addr/rd_data, uart_tx, busy, done).
module sweep_uart_dump
  import sweep_uart_dump_pkg::*;
#(
  parameter int unsigned NUM_POINTS = 200,
  parameter int unsigned CLK_DIV    = 104
) (
  input logic               clk,
  input logic               rst,
  sweep_uart_dump_if.slave  bus
);

  localparam logic [7:0] LAST_IDX =
    8'(NUM_POINTS - 1);

  state_e      state;
  logic [7:0]  index;
  logic [11:0] hold;
  logic [2:0]  char_idx;
  logic [7:0]  ch;
  logic        valid;
  logic        ready;
  logic        fin;
  logic        tx;

  assign valid = (state == S_SEND);
  assign bus.uart_tx = tx;

  always_comb begin
    ch = LF;
    unique case (char_idx)
      3'd0:    ch = hex_ascii(hold[11:8]);
      3'd1:    ch = hex_ascii(hold[7:4]);
      3'd2:    ch = hex_ascii(hold[3:0]);
      3'd3:    ch = CR;
      default: ch = LF;
    endcase
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (ch),
    .ready (ready),
    .fin   (fin),
    .tx    (tx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      index       <= '0;
      hold        <= '0;
      char_idx    <= '0;
      bus.rd_addr <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            index    <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          bus.rd_addr <= index;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          hold     <= bus.rd_data;
          char_idx <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (ready) begin
            if (char_idx == LAST_CHAR)
              state <= S_NEXT;
            else
              char_idx <= char_idx + 3'd1;
          end
        end
        S_NEXT: begin
          if (index == LAST_IDX) begin
            state <= S_DRAIN;
          end else begin
            index <= index + 8'd1;
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // fin lets done land right after
          // the last stop bit's final clock
          if (fin || ready) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
